// File: rtl/finv_table_gen.sv
// Boot-time generator for the reciprocal unit's constant/gradient tables.
// One serial restoring divider produces r(k) = floor(2^34/(1024+k)); each entry is written 26 cycles apart.
module finv_table_gen #(
  parameter int IDX_W = 10,
  parameter int C_W   = 23,
  parameter int G_W   = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [IDX_W-1:0] addr,
  output logic [C_W-1:0]   c_data,
  output logic [G_W-1:0]   g_data
);
  localparam int R_W    = C_W + 2;           // quotient width, holds r(0) = 2^(C_W+1)
  localparam int D_W    = IDX_W + 2;         // divisor width, 1024+k
  localparam int STEP_W = $clog2(R_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [R_W-1:0]    R_FIRST = {1'b1, {(R_W-1){1'b0}}};
  localparam logic [R_W-1:0]    R_LAST  = {2'b01, {C_W{1'b0}}};
  // Dividend bits above the quotient window leave this partial remainder (2^34 >> 25).
  localparam logic [D_W-1:0]    REM0    = D_W'(1) << (IDX_W - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(R_W - 1);

  logic [1:0]        state;
  logic [IDX_W:0]    k;
  logic [R_W-1:0]    r_prev, quotient;
  logic [D_W-1:0]    remainder;
  logic [STEP_W-1:0] step;

  logic [D_W-1:0] divisor;
  logic [D_W:0]   rem_sh;
  logic           rem_ge;
  logic [D_W-1:0] rem_nx;
  logic [R_W-1:0] q_nx, r_cur, c_diff, g_half;
  logic [C_W-1:0] c_sat;
  logic [G_W-1:0] g_sat;

  always_comb begin
    divisor = {2'b01, k[IDX_W-1:0]};
    rem_sh  = {remainder, 1'b0};
    rem_ge  = rem_sh >= {1'b0, divisor};
    rem_nx  = rem_ge ? D_W'(rem_sh - {1'b0, divisor}) : rem_sh[D_W-1:0];
    q_nx    = {quotient[R_W-2:0], rem_ge};
    // The final entry's upper neighbour is the exact constant 2^23; no division needed.
    r_cur   = k[IDX_W] ? R_LAST : q_nx;
    c_diff  = r_prev - R_LAST;
    g_half  = R_W'((r_prev - r_cur) >> 1);
    c_sat   = (c_diff[R_W-1:C_W] != '0) ? {C_W{1'b1}} : c_diff[C_W-1:0];
    g_sat   = (g_half[R_W-1:G_W] != '0) ? {G_W{1'b1}} : g_half[G_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      k         <= '0;
      r_prev    <= '0;
      quotient  <= '0;
      remainder <= '0;
      step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      c_data    <= '0;
      g_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r_prev    <= R_FIRST;
            k         <= (IDX_W+1)'(1);
            busy      <= 1'b1;
            remainder <= REM0;
            quotient  <= '0;
            step      <= '0;
            state     <= S_DIV;
          end
        end
        S_DIV: begin
          remainder <= rem_nx;
          quotient  <= q_nx;
          step      <= step + 1'b1;
          if (step == STEP_LAST) begin
            quotient <= r_cur;
            we       <= 1'b1;
            addr     <= k[IDX_W-1:0] - 1'b1;
            c_data   <= c_sat;
            g_data   <= g_sat;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          we        <= 1'b0;
          r_prev    <= quotient;
          k         <= k + 1'b1;
          remainder <= REM0;
          quotient  <= '0;
          step      <= '0;
          if (addr == {IDX_W{1'b1}}) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_finv_table_gen.sv
// Bench for finv_table_gen: full table sweeps against an arithmetic model of r(k),
// spot vectors, start-while-busy / start-in-DONE, and asynchronous abort mid-build.
module tb_finv_table_gen;
  logic        clk = 1'b0;
  logic        rstn, start;
  logic        busy, done, we;
  logic [9:0]  addr;
  logic [22:0] c_data;
  logic [12:0] g_data;

  finv_table_gen dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .we(we), .addr(addr), .c_data(c_data), .g_data(g_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint exp_c [1024];
  longint exp_g [1024];
  longint cap_c [1024];
  longint cap_g [1024];

  typedef struct {
    int     idx;
    longint c;
    longint g;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic longint r_of(input int k);
    if (k == 0)    return longint'(1) << 24;
    if (k == 1024) return longint'(1) << 23;
    return (longint'(1) << 34) / longint'(1024 + k);
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_we"},   longint'(we), 0);
    chk({tag, "_addr"}, longint'(addr), 0);
    chk({tag, "_c"},    longint'(c_data), 0);
    chk({tag, "_g"},    longint'(g_data), 0);
  endtask

  // Runs one build from a start pulse. abort_at > 0 pulls rstn low at that cycle;
  // poke_at > 0 re-asserts start for one cycle while the build is running.
  task automatic build(input int abort_at, input int poke_at);
    int  nwr;
    bit  finished;
    nwr = 0;
    finished = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 27000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_rise", longint'(busy), 1);
        chk("we_early", longint'(we), 0);
      end
      if (poke_at > 0 && cyc == poke_at) start = 1'b1;
      if (poke_at > 0 && cyc == poke_at + 1) start = 1'b0;
      if (abort_at > 0 && cyc == abort_at) begin
        rstn = 1'b0;
        #1;
        check_zero_outputs("abort");
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (j == 10) rstn = 1'b1;
          chk("abort_no_done", longint'(done), 0);
          chk("abort_no_we", longint'(we), 0);
        end
        return;
      end
      if (we) begin
        if (nwr < 1024) begin
          chk("wr_cycle", longint'(cyc), longint'(26 * (nwr + 1)));
          chk("wr_addr", longint'(addr), longint'(nwr));
          chk("wr_c", longint'(c_data), exp_c[nwr]);
          chk("wr_g", longint'(g_data), exp_g[nwr]);
          chk("wr_busy", longint'(busy), 1);
          cap_c[int'(addr)] = longint'(c_data);
          cap_g[int'(addr)] = longint'(g_data);
        end else begin
          chk("extra_write", longint'(nwr), 1023);
        end
        nwr++;
      end
      if (done) begin
        chk("done_cycle", longint'(cyc), 26625);
        chk("write_count", longint'(nwr), 1024);
        chk("busy_fall", longint'(busy), 0);
        finished = 1;
        // start during DONE must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 40; j++) begin
          chk("idle_busy", longint'(busy), 0);
          chk("idle_we", longint'(we), 0);
          @(negedge clk);
        end
        break;
      end
    end
    if (!finished) chk("build_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      longint d, g;
      d = r_of(i) - (longint'(1) << 23);
      exp_c[i] = (d > 64'h7FFFFF) ? 64'h7FFFFF : d;
      g = (r_of(i) - r_of(i + 1)) / 2;
      exp_g[i] = (g > 64'h1FFF) ? 64'h1FFF : g;
      cap_c[i] = -1;
      cap_g[i] = -1;
    end
    vecs[0] = '{idx: 0,    c: 64'h7FFFFF, g: 64'h1FF8};
    vecs[1] = '{idx: 512,  c: 64'h2AAAAA, g: exp_g[512]};
    vecs[2] = '{idx: 1023, c: 64'h1002,   g: 64'h801};

    rstn  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    build(0, 500);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("vec%0d_c", vecs[i].idx), cap_c[vecs[i].idx], vecs[i].c);
      chk($sformatf("vec%0d_g", vecs[i].idx), cap_g[vecs[i].idx], vecs[i].g);
    end

    for (int i = 0; i < 1024; i++) begin
      cap_c[i] = -1;
      cap_g[i] = -1;
    end
    build(10000, 0);
    repeat (3) @(negedge clk);

    build(0, int'($urandom_range(2, 26600)));
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = int'($urandom_range(0, 1023));
      chk($sformatf("rand%0d_c", idx), cap_c[idx], exp_c[idx]);
      chk($sformatf("rand%0d_g", idx), cap_g[idx], exp_g[idx]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
